dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single data DRAM port between N processor cores in the multi-core build. Today each core drives its own address register output, data register output and DRAM write enable.
- Each core raises a request carrying its address, read/write flag and write data. The arbiter grants one core at a time, using a round-robin policy.
- The arbiter sequences the DRAM access, returns read data and pulses a per-core done flag.
- It sits between the cores' AR/DR/DRAM_we outputs and the DRAM macro.

Parameters:
- N_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 12, DRAM address width (matches the AR width).
- DATA_W, 32, DRAM data width (matches the DR width).
- RD_LAT, 1, DRAM read latency in cycles from address valid to mem_rdata valid (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_CORES  per-core access request, held high until that core's done.
- req_we  in  N_CORES  per-core write flag: 1 = write, 0 = read.
- req_addr  in  N_CORES*ADDR_W  packed per-core addresses; core i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_CORES*DATA_W  packed per-core write data.
- gnt  out  N_CORES  one-hot grant, held for the whole access.
- done  out  N_CORES  one-cycle completion pulse to the owning core.
- rdata  out  DATA_W  read data, valid in the done cycle and held until the next read completes.
- mem_addr  out  ADDR_W  DRAM address.
- mem_wdata  out  DATA_W  DRAM write data.
- mem_we  out  1  DRAM write enable, single-cycle pulse.
- mem_rdata  in  DATA_W  DRAM read data.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; gnt=0; done=0; rdata=0; mem_addr=0; mem_wdata=0; mem_we=0.
  - rr_ptr=N_CORES-1, so core 0 has first priority.
  - Cnt=0.
  - Reset mid-access aborts the access immediately. mem_we drops and no done is issued. A requester still holding req is re-arbitrated after reset release.
- State IDLE:
  - If any req bit is set, the winner is the first set bit found scanning upward from rr_ptr+1, modulo N_CORES.
  - Register owner, gnt=onehot(owner), mem_addr, mem_wdata, the we flag, and Cnt=RD_LAT. Go to ACCESS.
  - If no req bit is set, stay in IDLE with all outputs idle.
- State ACCESS (exactly 1 cycle):
  - mem_addr and mem_wdata are valid; mem_we=latched we.
  - Writes go to RESP. Reads go to WAIT.
- State WAIT:
  - Cnt decrements each cycle.
  - When Cnt reaches 1, capture mem_rdata into rdata at that edge and go to RESP.
  - Read data is therefore sampled exactly RD_LAT cycles after mem_addr first became valid.
- State RESP (1 cycle):
  - done[owner]=1 and gnt stays asserted.
  - rr_ptr=owner. Next state is IDLE, with gnt cleared.
- Latency, req first seen high in cycle T:
  - gnt and mem signals appear at T+1.
  - Write: done at T+2.
  - Read: done at T+2+RD_LAT.
  - Minimum spacing between grants is 3 cycles for writes and 3+RD_LAT cycles for reads.
- mem_addr and mem_wdata hold their values from grant through RESP. mem_we is high only in ACCESS.
- A write leaves rdata unchanged.
- If req drops during ACCESS or WAIT, the access still completes and done still pulses. The requester must ignore it.
- New or changed req_addr, req_we or req_wdata after grant are ignored, because the values were latched in IDLE.
- Simultaneous requests: exactly one gnt bit is ever high. No core waits more than N_CORES-1 other accesses.
- Out-of-range width parameters are not supported; no checking is done.

Decomposition:
- Package dram_arb_pkg holds:
  - the state enum (IDLE, ACCESS, WAIT, RESP);
  - default constants N_CORES_D=4, ADDR_W_D=12, DATA_W_D=32;
  - the RD_LAT width constant.
- One sub-module, rr_pick:
  - purely combinational;
  - inputs: req vector and rr_ptr;
  - outputs: any_req and the winner index;
  - reused later by the register-file port arbiter.

Test Plan (N_CORES=4, RD_LAT=1):
- Reset with rst=0, then release with all req=0 -> all outputs stay 0 and state is IDLE for 10 cycles.
- Core 2 write, req=0100, addr=0x0A5, wdata=0xDEADBEEF -> gnt=0100 at T+1; mem_we=1 for exactly 1 cycle with mem_addr=0x0A5 and mem_wdata=0xDEADBEEF; done=0100 at T+2.
- Core 1 read, addr=0x0A5, DRAM model returns 0xDEADBEEF -> done=0010 at T+3 with rdata=0xDEADBEEF; mem_we stays 0.
- All four cores request reads continuously from reset -> grant order is 0,1,2,3,0. gnt is always one-hot, and done spacing is 4 cycles.
- Core 3 drops req during WAIT -> done=1000 still pulses at T+3; the next grant goes to the next requesting core in round-robin order.
- Assert rst during core 0's WAIT -> gnt=0, mem_we=0 and no done pulse. After release, with req=0001 held, core 0 is re-granted 1 cycle later.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM port arbiter.
// The state encoding and counter width are also used by the register-file arbiter.
package dram_arb_pkg;

    localparam int N_CORES_D  = 4;
    localparam int ADDR_W_D   = 12;
    localparam int DATA_W_D   = 32;
    localparam int RD_LAT_MAX = 4;

    // Wide enough to hold RD_LAT_MAX itself.
    localparam int CNT_W = $clog2(RD_LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit
// scanning upward from ptr_i+1, wrapping modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] win_o
);

    always_comb begin
        int cand;
        cand  = 0;
        any_o = 1'b0;
        win_o = '0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[IDX_W'(cand)]) begin
                any_o = 1'b1;
                win_o = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM port between N cores. One access is in
// flight at a time; request fields are latched at grant and later changes ignored.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int N_CORES = N_CORES_D,
    parameter int ADDR_W  = ADDR_W_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,        // asynchronous, active low
    input  logic [N_CORES-1:0]        req_i,
    input  logic [N_CORES-1:0]        req_we_i,
    input  logic [N_CORES*ADDR_W-1:0] req_addr_i,
    input  logic [N_CORES*DATA_W-1:0] req_wdata_i,
    output logic [N_CORES-1:0]        gnt_o,
    output logic [N_CORES-1:0]        done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    output logic                      mem_we_o,
    input  logic [DATA_W-1:0]         mem_rdata_i
);

    localparam int               IDX_W    = idx_w(N_CORES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT);

    arb_state_e          state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    owner_q;
    logic                we_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [N_CORES-1:0]  gnt_q;
    logic [N_CORES-1:0]  done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_we_q;

    logic                any_req;
    logic [IDX_W-1:0]    win;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    rr_pick #(
        .N     (N_CORES),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .any_o (any_req),
        .win_o (win)
    );

    assign win_addr  = req_addr_i[int'(win)*ADDR_W +: ADDR_W];
    assign win_wdata = req_wdata_i[int'(win)*DATA_W +: DATA_W];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDX_W'(N_CORES - 1);
            owner_q     <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            // done and mem_we are single-cycle pulses unless re-set below.
            done_q   <= '0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q     <= win;
                        gnt_q       <= N_CORES'(1) << win;
                        mem_addr_q  <= win_addr;
                        mem_wdata_q <= win_wdata;
                        we_q        <= req_we_i[win];
                        mem_we_q    <= req_we_i[win];
                        cnt_q       <= CNT_INIT;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        done_q  <= gnt_q;
                        state_q <= RESP;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // Capturing at Cnt==1 samples mem_rdata RD_LAT cycles after the address.
                    if (cnt_q == CNT_W'(1)) begin
                        rdata_q <= mem_rdata_i;
                        done_q  <= gnt_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    rr_ptr_q    <= owner_q;
                    gnt_q       <= '0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized multi-core traffic.
module tb_dram_arbiter;

    localparam int NC = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int RL = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NC-1:0]     req = '0;
    logic [NC-1:0]     req_we = '0;
    logic [AW-1:0]     c_addr [NC];
    logic [DW-1:0]     c_wd   [NC];
    logic [NC*AW-1:0]  req_addr;
    logic [NC*DW-1:0]  req_wdata;
    logic [NC-1:0]     gnt, done;
    logic [DW-1:0]     rdata, mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NC; i++) begin
            req_addr[i*AW +: AW]  = c_addr[i];
            req_wdata[i*DW +: DW] = c_wd[i];
        end
    end

    dram_arbiter #(
        .N_CORES (NC),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RD_LAT  (RL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .gnt_o       (gnt),
        .done_o      (done),
        .rdata_o     (rdata),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_we_o    (mem_we),
        .mem_rdata_i (mem_rdata)
    );

    // DRAM macro stand-in with 1-cycle read latency
    logic [DW-1:0] dram [0:(1<<AW)-1];
    logic [DW-1:0] mmem [0:(1<<AW)-1];

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a * 32'h0100_0193 + 32'h1357);
    endfunction

    always @(posedge clk) begin
        if (mem_we) dram[mem_addr] <= mem_wdata;
        mem_rdata <= dram[mem_addr];
    end

    // Reference model: one transaction at a time, phase given by age since grant.
    bit            m_busy = 1'b0;
    int            m_owner = 0;
    int            m_age = 0;
    int            m_done_age = 0;
    int            m_ptr = NC - 1;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0;
    logic [DW-1:0] m_rdata = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy  = 1'b0;
            m_ptr   = NC - 1;
            m_rdata = '0;
        end else if (!m_busy) begin
            for (int k = 1; k <= NC; k++) begin
                int c;
                c = (m_ptr + k) % NC;
                if (!m_busy && req[c]) begin
                    m_busy     = 1'b1;
                    m_owner    = c;
                    m_age      = 0;
                    m_we       = req_we[c];
                    m_addr     = c_addr[c];
                    m_wd       = c_wd[c];
                    m_done_age = m_we ? 1 : 1 + RL;
                    if (m_we) mmem[m_addr] = m_wd;
                end
            end
        end else if (m_age == m_done_age) begin
            m_busy = 1'b0;
            m_ptr  = m_owner;
        end else begin
            m_age++;
            if (m_age == m_done_age && !m_we) m_rdata = mmem[m_addr];
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [NC-1:0] eg;
        eg = m_busy ? (NC'(1) << m_owner) : '0;
        cmp("m_gnt", 32'(gnt), 32'(eg));
        cmp("m_done", 32'(done), (m_busy && m_age == m_done_age) ? 32'(eg) : 32'h0);
        cmp("m_mem_we", 32'(mem_we), 32'(m_busy && m_age == 0 && m_we));
        cmp("m_mem_addr", 32'(mem_addr), m_busy ? 32'(m_addr) : 32'h0);
        cmp("m_mem_wdata", mem_wdata, m_busy ? m_wd : 32'h0);
        cmp("m_rdata", rdata, m_rdata);
    end

    task automatic reset_cycle();
        #1 rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    int       g_q[$];
    int       d_q[$];
    int       cyc;
    logic [NC-1:0] prev_gnt;
    bit [NC-1:0]   pend;

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            dram[a] = init_val(a);
            mmem[a] = init_val(a);
        end
        for (int i = 0; i < NC; i++) begin
            c_addr[i] = '0;
            c_wd[i]   = '0;
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        // Idle after reset
        repeat (10) @(negedge clk);
        cmp("idle_ctl", 32'({gnt, done, mem_we}), 32'h0);
        cmp("idle_data", rdata | mem_wdata | 32'(mem_addr), 32'h0);

        // Core 2 write
        #1 c_addr[2] = 12'h0A5; c_wd[2] = 32'hDEADBEEF; req_we = 4'b0100; req = 4'b0100;
        @(negedge clk);
        cmp("w_gnt", 32'(gnt), 32'h4);
        cmp("w_we", 32'(mem_we), 32'h1);
        cmp("w_addr", 32'(mem_addr), 32'h0A5);
        cmp("w_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        cmp("w_done", 32'(done), 32'h4);
        cmp("w_we_pulse", 32'(mem_we), 32'h0);
        #1 req = '0; req_we = '0;
        @(negedge clk);
        cmp("w_release", 32'(gnt), 32'h0);

        // Core 1 read of the same address
        #1 c_addr[1] = 12'h0A5; req = 4'b0010;
        @(negedge clk);
        cmp("r_gnt", 32'(gnt), 32'h2);
        cmp("r_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        cmp("r_nodone", 32'(done), 32'h0);
        @(negedge clk);
        cmp("r_done", 32'(done), 32'h2);
        cmp("r_rdata", rdata, 32'hDEADBEEF);
        #1 req = '0;
        repeat (2) @(negedge clk);

        // All four cores read continuously from reset
        #1 rst = 1'b0; req = '0;
        repeat (2) @(negedge clk);
        #1 for (int i = 0; i < NC; i++) c_addr[i] = AW'(12'h010 + i);
        req_we = '0; req = 4'b1111; rst = 1'b1;
        prev_gnt = '0;
        for (cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            if (gnt != 0 && gnt != prev_gnt) g_q.push_back($clog2(gnt));
            if (done != 0) d_q.push_back(cyc);
            prev_gnt = gnt;
        end
        for (int i = 0; i < 5; i++)
            cmp("rr_order", (g_q.size() > i) ? 32'(g_q[i]) : 32'hFFFF_FFFF, 32'(i % NC));
        for (int i = 1; i < 5; i++)
            cmp("rr_spacing", (d_q.size() > i) ? 32'(d_q[i] - d_q[i-1]) : 32'hFFFF_FFFF, 32'd4);
        #1 req = '0;
        repeat (6) @(negedge clk);

        // Core 3 drops req during WAIT
        reset_cycle();
        #1 c_addr[3] = 12'h020; req_we = '0; req = 4'b1000;
        @(negedge clk);
        cmp("drop_gnt", 32'(gnt), 32'h8);
        #1 c_addr[0] = 12'h030; c_addr[1] = 12'h031; req = 4'b1011;
        @(negedge clk);
        #1 req = 4'b0011;
        @(negedge clk);
        cmp("drop_done", 32'(done), 32'h8);
        @(negedge clk);
        cmp("drop_idle", 32'(gnt), 32'h0);
        @(negedge clk);
        cmp("drop_next", 32'(gnt), 32'h1);
        #1 req = '0;
        repeat (8) @(negedge clk);

        // Reset during core 0 WAIT
        reset_cycle();
        #1 c_addr[0] = 12'h040; req_we = '0; req = 4'b0001;
        @(negedge clk);
        cmp("rst_pre_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        cmp("rst_gnt_async", 32'(gnt), 32'h0);
        cmp("rst_we_async", 32'(mem_we), 32'h0);
        @(negedge clk);
        cmp("rst_no_done", 32'(done), 32'h0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        cmp("rst_regrant", 32'(gnt), 32'h1);
        #1 req = '0;
        repeat (6) @(negedge clk);

        // Randomized traffic
        pend = '0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NC; i++) begin
                if (pend[i] && done[i]) begin
                    pend[i] = 1'b0;
                    req[i]  = 1'b0;
                end else if (!pend[i] && !gnt[i] && ($urandom % 3 == 0)) begin
                    pend[i]   = 1'b1;
                    req[i]    = 1'b1;
                    req_we[i] = 1'($urandom % 2);
                    c_addr[i] = AW'(($urandom % 16) | (($urandom % 2) ? 32'hF00 : 32'h0));
                    c_wd[i]   = $urandom;
                end else if (pend[i] && gnt[i] && !done[i]) begin
                    if ($urandom % 8 == 0) begin
                        c_addr[i] = AW'($urandom);
                        c_wd[i]   = $urandom;
                        req_we[i] = ~req_we[i];
                    end
                    if ($urandom % 16 == 0) begin
                        req[i]  = 1'b0;
                        pend[i] = 1'b0;
                    end
                end
            end
        end
        #1 req = '0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
